// File: rtl/wave_pixel_gen.sv
// Pixel-colour stage behind the VGA timing block: scrolling sine-wave surface.
// Two-stage pipeline; colour and delayed syncs leave aligned.
module wave_pixel_gen #(
  parameter logic [9:0]  H_OFFSET  = 10'd144,
  parameter logic [10:0] V_OFFSET  = 11'd35,
  parameter logic [10:0] CENTER_Y  = 11'd240,
  parameter logic [10:0] THICK     = 11'd2,
  parameter logic [11:0] SKY_RGB   = 12'h48F,
  parameter logic [11:0] WATER_RGB = 12'h035,
  parameter logic [11:0] WAVE_RGB  = 12'hFFF
) (
  input  logic       vga_clock,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       at_display_area,
  input  logic [3:0] speed,
  input  logic [1:0] amp,
  input  logic       freeze,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic [6:0] QTAB [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,
    7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,
    7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,
    7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,
    7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111,
    7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121,
    7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [7:0]         r_phase;
  logic signed [7:0]  r_s;
  logic [10:0]        r_y;
  logic [1:0]         r_amp;
  logic               r_disp;
  logic               r_hs1;
  logic               r_vs1;
  logic [11:0]        r_rgb;
  logic               r_hs2;
  logic               r_vs2;

  logic [7:0]         w_a;
  logic [6:0]         w_idx;
  logic [6:0]         w_mag;
  logic [7:0]         w_sin;
  logic signed [7:0]  w_sh;
  logic signed [10:0] w_ss;
  logic signed [10:0] w_wy;
  logic signed [10:0] w_d;
  logic [11:0]        w_rgb;
  logic               w_origin;

  assign w_origin = (hcount == 10'd0) && (vcount == 10'd0);

  // Quarter table mirrored across a=64; upper half-period negated.
  always_comb begin
    w_a   = hcount[7:0] - H_OFFSET[7:0] + r_phase;
    w_idx = w_a[6:0];
    w_mag = 7'd0;
    if (w_idx == 7'd64)
      w_mag = 7'd127;
    else if (!w_idx[6])
      w_mag = QTAB[w_idx[5:0]];
    else
      w_mag = QTAB[6'd0 - w_idx[5:0]];
    w_sin = w_a[7] ? (8'd0 - {1'b0, w_mag})
                   : {1'b0, w_mag};
  end

  always_comb begin
    w_sh = r_s;
    case (r_amp)
      2'd0:    w_sh = r_s >>> 2;
      2'd1:    w_sh = r_s >>> 1;
      default: w_sh = r_s;
    endcase
    w_ss = {{3{w_sh[7]}}, w_sh};
    w_wy = $signed(CENTER_Y) - w_ss;
    w_d  = $signed(r_y) - w_wy;
    w_rgb = WATER_RGB;
    if (!r_disp)
      w_rgb = 12'h000;
    else if ((w_d <= $signed(THICK)) &&
             (w_d >= -$signed(THICK)))
      w_rgb = WAVE_RGB;
    else if (w_d < 0)
      w_rgb = SKY_RGB;
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 8'd0;
    end else if (w_origin && !freeze) begin
      r_phase <= r_phase + {4'd0, speed};
    end
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s    <= 8'sd0;
      r_y    <= 11'd0;
      r_amp  <= 2'd0;
      r_disp <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_rgb  <= 12'h000;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_s    <= w_sin;
      r_y    <= {1'b0, vcount} - V_OFFSET;
      r_amp  <= amp;
      r_disp <= at_display_area;
      r_hs1  <= hsync;
      r_vs1  <= vsync;
      r_rgb  <= w_rgb;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign vga_r     = r_rgb[11:8];
  assign vga_g     = r_rgb[7:4];
  assign vga_b     = r_rgb[3:0];
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;

endmodule

// File: tb/tb_wave_pixel_gen.sv
// Scoreboard bench for wave_pixel_gen: expected {rgb,hs,vs} queued per
// driven pixel, popped two cycles later against the DUT outputs.
module tb_wave_pixel_gen;

  localparam real PI = 3.14159265358979;

  typedef struct {
    int h; int v; bit d; bit hs; bit vs;
    int am; int sp; bit fz;
  } stim_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs;
  logic       vs;
  logic       disp;
  logic [3:0] speed;
  logic [1:0] amp;
  logic       freeze;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       hsync_out;
  logic       vsync_out;
  logic [13:0] obs;

  int checks = 0;
  int failures = 0;
  int ph_m = 0;
  logic [13:0] q[$];
  logic [13:0] e;

  wave_pixel_gen dut (
    .vga_clock(clk),
    .reset_n(rst_n),
    .hcount(hc),
    .vcount(vc),
    .hsync(hs),
    .vsync(vs),
    .at_display_area(disp),
    .speed(speed),
    .amp(amp),
    .freeze(freeze),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  assign obs = {vga_r, vga_g, vga_b, hsync_out, vsync_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_s(int a);
    real r;
    r = 127.0 * $sin(2.0 * PI * a / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int model_wy(int h, int am, int ph);
    int a, s, ss;
    a = (h - 144 + ph) & 255;
    s = model_s(a);
    if (am == 0) ss = s >>> 2;
    else if (am == 1) ss = s >>> 1;
    else ss = s;
    return 240 - ss;
  endfunction

  function automatic logic [11:0] model_rgb(int h, int v, bit d,
                                            int am, int ph);
    int dy;
    if (!d) return 12'h000;
    dy = (v - 35) - model_wy(h, am, ph);
    if (dy <= 2 && dy >= -2) return 12'hFFF;
    if (dy < 0) return 12'h48F;
    return 12'h035;
  endfunction

  function automatic stim_t mk(int h, int v, bit d, bit hsy, bit vsy,
                               int am, int sp, bit fz);
    stim_t t;
    t.h = h; t.v = v; t.d = d; t.hs = hsy; t.vs = vsy;
    t.am = am; t.sp = sp; t.fz = fz;
    return t;
  endfunction

  task automatic drv(input int h, input int v, input bit d,
                     input bit hsy, input bit vsy);
    hc = 10'(h);
    vc = 10'(v);
    disp = d;
    hs = hsy;
    vs = vsy;
    q.push_back({model_rgb(h, v, d, int'(amp), ph_m), hsy, vsy});
    if (h == 0 && v == 0 && !freeze)
      ph_m = (ph_m + int'(speed)) & 255;
  endtask

  task automatic apply(input stim_t t);
    int v;
    amp = 2'(t.am);
    speed = 4'(t.sp);
    freeze = t.fz;
    v = (t.v < 0) ? model_wy(t.h, t.am, ph_m) + 35 : t.v;
    drv(t.h, v, t.d, t.hs, t.vs);
  endtask

  task automatic test_reset;
    hc = 10'd144; vc = 10'd275; disp = 1'b1;
    hs = 1'b1; vs = 1'b1;
    amp = 2'd2; speed = 4'd0; freeze = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== 14'h0) begin
        failures++;
        $display("FAIL reset_hold obs=%h exp=%h", obs, 14'h0);
      end
    end
    rst_n = 1'b1;
    q.delete();
    ph_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL reset_pre obs=%h exp=%h", obs, e);
        end
      end
      drv(144, 275, 1'b1, 1'b1, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_async obs=%h exp=%h", obs, 14'h0);
    end
    q.delete();
    ph_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_crest;
    stim_t st[$];
    st.push_back(mk(144, 275, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(144, 100, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(144, 400, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(145, 275, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL crest i=%0d obs=%h exp=%h", i, obs, e);
        end
      end
      apply(st[i]);
    end
    q.delete();
  endtask

  task automatic test_peak;
    stim_t st[$];
    st.push_back(mk(208, 148, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 146, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 145, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 144, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 150, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 151, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(208, 244, 1, 0, 0, 0, 0, 0));
    st.push_back(mk(208, 228, 1, 0, 0, 1, 0, 0));
    st.push_back(mk(336, 367, 1, 0, 0, 3, 0, 0));
    st.push_back(mk(336, 272, 1, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL peak i=%0d obs=%h exp=%h", i, obs, e);
        end
      end
      apply(st[i]);
    end
    q.delete();
  endtask

  task automatic test_phase;
    stim_t st[$];
    repeat (3) st.push_back(mk(0, 0, 0, 0, 0, 2, 5, 0));
    for (int x = 0; x < 256; x++)
      st.push_back(mk(144 + x, -1, 1, 0, 0, 2, 5, 0));
    repeat (15) st.push_back(mk(0, 0, 0, 0, 0, 2, 15, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2, 14, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2, 5, 0));
    for (int x = 0; x < 256; x++)
      st.push_back(mk(144 + x, -1, 1, 0, 0, 2, 5, 0));
    repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 2, 5, 1));
    for (int x = 0; x < 256; x++)
      st.push_back(mk(144 + x, -1, 1, 0, 0, 2, 5, 1));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL phase i=%0d obs=%h exp=%h", i, obs, e);
        end
      end
      apply(st[i]);
    end
    q.delete();
    freeze = 1'b0;
  endtask

  task automatic test_blank;
    stim_t st[$];
    st.push_back(mk(144, 275, 0, 0, 0, 2, 0, 0));
    st.push_back(mk(144, 275, 1, 1, 0, 2, 0, 0));
    st.push_back(mk(150, 100, 1, 0, 1, 2, 0, 0));
    st.push_back(mk(160, 400, 1, 1, 1, 2, 0, 0));
    st.push_back(mk(170, 275, 0, 1, 0, 2, 0, 0));
    st.push_back(mk(300, 300, 1, 0, 0, 2, 0, 0));
    st.push_back(mk(310, 120, 1, 1, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL blank i=%0d obs=%h exp=%h", i, obs, e);
        end
      end
      apply(st[i]);
    end
    q.delete();
  endtask

  task automatic test_frame;
    int lines[$];
    bit d;
    lines = '{0, 34, 35};
    for (int v = 100; v <= 430; v += 6) lines.push_back(v);
    lines.push_back(514);
    lines.push_back(515);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    ph_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    amp = 2'd2;
    speed = 4'd0;
    freeze = 1'b0;
    foreach (lines[li]) begin
      for (int h = 0; h < 800; h++) begin
        @(negedge clk);
        if (q.size() == 2) begin
          e = q.pop_front();
          checks++;
          if (obs !== e) begin
            failures++;
            $display("FAIL frame v=%0d h=%0d obs=%h exp=%h",
                     lines[li], h, obs, e);
          end
        end
        d = (h >= 144) && (h < 784) &&
            (lines[li] >= 35) && (lines[li] < 515);
        drv(h, lines[li], d, h < 96, lines[li] < 2);
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL frame_tail obs=%h exp=%h", obs, e);
        end
      end
      drv(1, 1, 1'b0, 1'b0, 1'b0);
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_crest();
    test_peak();
    test_phase();
    test_blank();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
